// File: rtl/helios_channel_pkg.sv
// Shared constants and helpers for the helios non-blocking channel.
// Used by both channel endpoints and their storage sub-blocks.
package helios_channel_pkg;

    localparam int unsigned CHANNEL_WIDTH = 8;

    // Drop counter width; the counter holds at all-ones once reached.
    localparam int unsigned DROP_CNT_WIDTH = 8;
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

    function automatic int unsigned ptr_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/nb_rx_fifo_mem.sv
// Register-array storage for the channel receive FIFO.
// One synchronous write port, one combinational read port.
module nb_rx_fifo_mem
    import helios_channel_pkg::*;
#(
    parameter int unsigned WIDTH = CHANNEL_WIDTH,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nonblocking_channel_rx.sv
// Receive endpoint of the non-blocking channel: absorbs an unstallable
// stream into a fall-through FIFO and accounts for every dropped word.
module nonblocking_channel_rx
    import helios_channel_pkg::*;
#(
    parameter int unsigned WIDTH     = CHANNEL_WIDTH,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = DROP_CNT_WIDTH,
    localparam int unsigned PW       = ptr_width(DEPTH),
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_count,
    input  logic                 clear_overflow
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] SAT_CNT = '1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop frees the slot on the same edge, so a full FIFO still accepts.
    assign accept    = in_valid & (~full | pop);
    assign drop      = in_valid & full & ~pop;

    nb_rx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !accept) begin
                count <= count - CW'(1);
            end
        end
    end

    // A drop on the clearing edge is counted after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow) begin
                drop_count <= CNT_WIDTH'(1);
            end else if (drop_count != SAT_CNT) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_nonblocking_channel_rx.sv
// Directed vector bench for the channel receive endpoint.
// Table-driven vectors plus hand sequences for multi-cycle corners.
module tb_nonblocking_channel_rx;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CN = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count;
    logic          overflow;
    logic [CN-1:0] drop_count;
    logic          clear_overflow;

    always #5 clk = ~clk;

    nonblocking_channel_rx #(
        .WIDTH     (W),
        .DEPTH     (D),
        .CNT_WIDTH (CN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    typedef struct {
        logic         iv;
        logic [7:0]   id;
        logic         rdy;
        logic         clr;
        logic [2:0]   ecnt;
        logic         ev;
        logic [7:0]   ed;
        logic         eov;
        logic [7:0]   edc;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(
        logic iv, logic [7:0] id, logic rdy, logic clr,
        logic [2:0] ecnt, logic ev, logic [7:0] ed,
        logic eov, logic [7:0] edc);
        vec_t v;
        v.iv = iv; v.id = id; v.rdy = rdy; v.clr = clr;
        v.ecnt = ecnt; v.ev = ev; v.ed = ed;
        v.eov = eov; v.edc = edc;
        return v;
    endfunction

    task automatic check(
        string name, logic [2:0] ecnt, logic ev,
        logic [7:0] ed, logic eov, logic [7:0] edc);
        tests++;
        if (count !== ecnt || out_valid !== ev ||
            (ev && out_data !== ed) ||
            overflow !== eov || drop_count !== edc) begin
            fails++;
            $display({"FAIL %s: got cnt=%0d v=%0b d=%02h ov=%0b dc=%0d,",
                      " want cnt=%0d v=%0b d=%02h ov=%0b dc=%0d"},
                     name, count, out_valid, out_data, overflow,
                     drop_count, ecnt, ev, ed, eov, edc);
        end
    endtask

    task automatic step(logic iv, logic [7:0] id,
                        logic rdy, logic clr);
        in_valid       = iv;
        in_data        = id;
        out_ready      = rdy;
        clear_overflow = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // in: iv id rdy clr | exp: cnt v data ov dc
        vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(1, 8'hF0, 0, 0, 2, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(1, 8'h55, 0, 0, 3, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(1, 8'h0F, 0, 0, 4, 1, 8'hAA, 0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 4, 1, 8'hAA, 1, 1));
        vecs.push_back(mk(1, 8'h77, 1, 0, 4, 1, 8'hF0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3, 1, 8'h55, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'h0F, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h77, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1));
        vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 8'h01, 1, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 2, 1, 8'h01, 1, 1));
        vecs.push_back(mk(1, 8'h03, 0, 0, 3, 1, 8'h01, 1, 1));
        vecs.push_back(mk(1, 8'h04, 0, 0, 4, 1, 8'h01, 1, 1));
        vecs.push_back(mk(1, 8'h05, 0, 0, 4, 1, 8'h01, 1, 2));
        vecs.push_back(mk(1, 8'h06, 0, 0, 4, 1, 8'h01, 1, 3));
        vecs.push_back(mk(1, 8'h07, 0, 1, 4, 1, 8'h01, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 4, 1, 8'h01, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 3, 1, 8'h02, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 2, 1, 8'h03, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h04, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(1, 8'h10, 0, 0, 1, 1, 8'h10, 0, 0));
        vecs.push_back(mk(1, 8'h11, 1, 0, 1, 1, 8'h11, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0));

        reset          = 1'b1;
        in_valid       = 1'b0;
        in_data        = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, 0, 8'h00, 0, 0);
        reset = 1'b1;

        repeat (10) step(0, 8'h00, 0, 0);
        check("idle10", 0, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].id, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].ev,
                  vecs[i].ed, vecs[i].eov, vecs[i].edc);
        end

        // Streaming push+pop every cycle: head always the newest word.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] want;
            if (out_valid) begin
                want = 8'(i - 1);
                tests++;
                if (out_data !== want) begin
                    fails++;
                    $display("FAIL stream_pop%0d: got %02h want %02h",
                             i, out_data, want);
                end
            end
            step(1, 8'(i), out_valid, 0);
            check($sformatf("stream%0d", i), 1, 1, 8'(i), 0, 0);
        end
        step(0, 8'h00, 1, 0);
        check("stream_drain", 0, 0, 8'h00, 0, 0);

        // Fill, then 300 drops to reach and hold saturation.
        for (int i = 0; i < 4; i++) begin
            step(1, 8'hC0 + 8'(i), 0, 0);
        end
        check("sat_full", 4, 1, 8'hC0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            step(1, 8'hEE, 0, 0);
            if (i == 254) check("sat_254", 4, 1, 8'hC0, 1, 8'hFE);
            if (i == 255) check("sat_255", 4, 1, 8'hC0, 1, 8'hFF);
        end
        check("sat_300", 4, 1, 8'hC0, 1, 8'hFF);

        // Asynchronous reset away from any clock edge.
        #2 reset = 1'b0;
        #1;
        check("async_reset", 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        check("reset_hold", 0, 0, 8'h00, 0, 0);
        reset = 1'b1;
        step(1, 8'h5A, 0, 0);
        check("post_reset_push", 1, 1, 8'h5A, 0, 0);
        step(1, 8'h5B, 0, 0);
        check("post_reset_push2", 2, 1, 8'h5A, 0, 0);
        step(0, 8'h00, 1, 0);
        check("post_reset_pop", 1, 1, 8'h5B, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nonblocking_channel_rx.md
Name: nonblocking_channel_rx

Overview:
Receive-side endpoint of the non-blocking channel. It captures every word arriving on the channel's valid/data stream, which has no backpressure, into a small FIFO. It then presents the words to a local consumer over a ready/valid handshake. Overflow is never silent: dropped words set a sticky flag and increment a saturating counter, so decoder-side logic can detect loss.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_WIDTH, 8, width of the saturating drop counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_data  input  WIDTH  word from the channel
in_valid  input  1  in_data valid this cycle; cannot be stalled
out_data  output  WIDTH  head-of-FIFO word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head word this cycle
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: at least one word has been dropped
drop_count  output  CNT_WIDTH  number of dropped words, saturating
clear_overflow  input  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (reset==0, asynchronous): read pointer, write pointer and count = 0; out_valid=0; overflow=0; drop_count=0. out_data is don't-care while out_valid=0; the memory array is not reset.
- Push event: in_valid==1 at a rising edge.
- Pop event: out_valid==1 && out_ready==1 at the same edge. out_ready while empty is ignored.
- First-word fall-through: a word pushed at edge N is visible on out_data with out_valid=1 immediately after edge N, so latency is 1 cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr], read combinationally from the register array.
- Ordering is strict FIFO; no reordering or duplication.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Push only: if count<DEPTH, write mem[wr_ptr], advance wr_ptr, count+1. If count==DEPTH, the word is dropped (see drop rules).
- Pop only: advance rd_ptr, count-1.
- Push and pop together:
  - Always accepted, including when full, because the pop frees the slot in the same edge.
  - Both pointers advance; count unchanged.
  - When count==1, the new word becomes the head after the edge.
- Drop rules: on a dropped word, overflow<=1 and drop_count<=drop_count+1, saturating at all-ones.
- clear_overflow: overflow<=0 and drop_count<=0 at the edge.
  - If a drop occurs on the same edge, the drop wins the flag and is counted after the clear: overflow=1, drop_count=1.
- Reset asserted mid-stream: contents are discarded immediately and all outputs return to their reset values. The first push after deassertion lands in entry 0.
- The block never deasserts anything toward the channel, since the channel has no ready.

Decomposition:
- Shared package helios_channel_pkg:
  - default channel WIDTH constant
  - ptr_width(depth) function
  - drop-counter saturation constant
- One natural sub-module: nb_rx_fifo_mem, a DEPTH x WIDTH register array with one write port and a combinational read port.
- Pointer, count and overflow logic stay in the top level.

Test Plan:
- Reset, then idle 10 cycles -> out_valid=0, count=0, overflow=0, drop_count=0.
- Push 0xAA with out_ready=0 -> next cycle out_valid=1, out_data=0xAA, count=1. Raise out_ready for 1 cycle -> out_valid=0, count=0.
- Push 0xAA, 0xF0, 0x55, 0x0F back-to-back, out_ready=0 -> count=4. Push 0x33 -> count=4, overflow=1, drop_count=1. Drain -> words 0xAA, 0xF0, 0x55, 0x0F in order; 0x33 never appears.
- Full FIFO (count=4), push 0x77 with out_ready=1 on the same edge -> count stays 4, overflow unchanged; 0x77 emerges last after draining.
- Continuous push and pop for 20 cycles with incrementing data 0x00..0x13 -> output sequence 0x00..0x13, pointers wrap 5 times, no drops.
- With overflow=1, drop_count=3: assert clear_overflow together with a drop -> overflow=1, drop_count=1. Then force 300 drops -> drop_count saturates at 0xFF. Assert reset for 1 cycle mid-stream -> count=0, out_valid=0, overflow=0.
